// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master.
package spi_cfg_pkg;

  localparam int SPI_REG_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for sclk: a reloading down-counter that emits a one-cycle
// half_tick_o every CLK_DIV enabled cycles. clr_i restarts the period so the
// first tick lands exactly CLK_DIV cycles after the frame starts.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic half_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign half_tick_o = en_i && (cnt_q == '0);

  // Count down while enabled; terminal count reloads and produces the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= RELOAD;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_q <= RELOAD;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI master that writes a daisy chain of 8-bit configuration shift registers
// and returns the bits shifted out of the chain tail.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cs_b high, waiting for start
// SETUP | cs_b low, MSB on sdi, one half-period before first rising sclk
// SHIFT | sclk toggles each half-period; sample sdo on rise, advance sdi on fall
// HOLD  | sclk low, cs_b still low for one half-period after last fall
// LOAD  | cs_b high for one half-period (slave parallel load)
// DONE  | one-cycle done pulse, busy low; start accepted here too
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int N_REGS  = 1,
  parameter int CLK_DIV = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [SPI_REG_BITS*N_REGS-1:0]   wdata,
  output logic                             busy,
  output logic                             done,
  output logic [SPI_REG_BITS*N_REGS-1:0]   rdata,
  output logic                             sclk,
  output logic                             sdi,
  output logic                             cs_b,
  input  logic                             sdo
);

  localparam int B   = SPI_REG_BITS * N_REGS;
  localparam int BCW = $clog2(B + 1);

  spi_state_t      state_q;
  logic [B-1:0]    tx_q;
  logic [B-1:0]    rx_q;
  logic [B-1:0]    rdata_q;
  logic [BCW-1:0]  bits_left_q;
  logic            sclk_q;
  logic            sdi_q;
  logic            cs_b_q;
  logic            busy_q;
  logic            done_q;

  logic            half_tick;
  logic            idle_like;
  logic            accept;

  // DONE behaves like IDLE for accepting a new frame, which gives back-to-back
  // frames a cs_b high time of one half-period plus the DONE cycle.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = start && idle_like;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .en_i       (!idle_like),
    .clr_i      (accept),
    .half_tick_o(half_tick)
  );

  // Frame sequencer: all serial and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      bits_left_q <= '0;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      cs_b_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q     <= ST_SETUP;
            tx_q        <= wdata;
            sdi_q       <= wdata[B-1];
            rx_q        <= '0;
            bits_left_q <= BCW'(B);
            cs_b_q      <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          // First rising edge; sdo is taken before the chain shifts on it.
          if (half_tick) begin
            state_q     <= ST_SHIFT;
            sclk_q      <= 1'b1;
            rx_q        <= {rx_q[B-2:0], sdo};
            bits_left_q <= bits_left_q - BCW'(1);
          end
        end
        ST_SHIFT: begin
          if (half_tick) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
              if (bits_left_q == '0) begin
                state_q <= ST_HOLD;
                sdi_q   <= 1'b0;
              end else begin
                tx_q  <= {tx_q[B-2:0], 1'b0};
                sdi_q <= tx_q[B-2];
              end
            end else begin
              sclk_q      <= 1'b1;
              rx_q        <= {rx_q[B-2:0], sdo};
              bits_left_q <= bits_left_q - BCW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (half_tick) begin
            state_q <= ST_LOAD;
            cs_b_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (half_tick) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdata_q <= rx_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign sdi   = sdi_q;
  assign cs_b  = cs_b_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: shift-register chain models on the serial side,
// a queue of expected frame results, and a monitor that checks each done.
module tb_spi_cfg_master;

  localparam int NA = 1;
  localparam int HA = 4;
  localparam int BA = 8 * NA;
  localparam int NB = 4;
  localparam int HB = 1;
  localparam int BB = 8 * NB;
  localparam int FRAME_A = 1 + 2 * HA * BA + 2 * HA;
  localparam int FRAME_B = 1 + 2 * HB * BB + 2 * HB;
  localparam logic [BA-1:0] CHAIN_A_INIT = 8'h3C;
  localparam logic [BB-1:0] CHAIN_B_INIT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: one register, slow sclk
  logic          start_a = 1'b0;
  logic [BA-1:0] wdata_a = '0;
  logic          busy_a, done_a, sclk_a, sdi_a, cs_b_a, sdo_a;
  logic [BA-1:0] rdata_a;

  spi_cfg_master #(.N_REGS(NA), .CLK_DIV(HA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a),
    .sclk(sclk_a), .sdi(sdi_a), .cs_b(cs_b_a), .sdo(sdo_a)
  );

  // DUT B: four chained registers, fastest sclk
  logic          start_b = 1'b0;
  logic [BB-1:0] wdata_b = '0;
  logic          busy_b, done_b, sclk_b, sdi_b, cs_b_b, sdo_b;
  logic [BB-1:0] rdata_b;

  spi_cfg_master #(.N_REGS(NB), .CLK_DIV(HB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b),
    .sclk(sclk_b), .sdi(sdi_b), .cs_b(cs_b_b), .sdo(sdo_b)
  );

  // Slave chains: shift on sclk rise, parallel load on cs_b rise.
  logic [BA-1:0] chain_a = CHAIN_A_INIT;
  logic [BA-1:0] cfg_a = '0;
  assign sdo_a = chain_a[BA-1];
  always @(posedge sclk_a) chain_a <= {chain_a[BA-2:0], sdi_a};
  always @(posedge cs_b_a) cfg_a <= chain_a;

  logic [BB-1:0] chain_b = CHAIN_B_INIT;
  logic [BB-1:0] cfg_b = '0;
  assign sdo_b = chain_b[BB-1];
  always @(posedge sclk_b) chain_b <= {chain_b[BB-2:0], sdi_b};
  always @(posedge cs_b_b) cfg_b <= chain_b;

  typedef struct {
    logic [BA-1:0] rdata;
    logic [BA-1:0] cfg;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [BA-1:0] ref_chain = CHAIN_A_INIT;
  logic          gap_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pops one expected frame result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (done_a) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done seen at cycle %0d with no pending write", cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("rdata", rdata_a, e.rdata);
          check("cfg_loaded", cfg_a, e.cfg);
        end
      end
    end
  end

  // Frame shape monitor: cs_b low time, sclk rise count, inter-frame gap.
  initial begin
    int   low = 0, high = 0, rises = 0;
    logic sclk_prev = 1'b0, csb_prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!cs_b_a) begin
        if (csb_prev && gap_chk) check("cs_high_gap", high, HA + 1);
        low++;
        if (sclk_a && !sclk_prev) rises++;
        high = 0;
      end else begin
        if (!csb_prev && !rst) begin
          check("cs_low_cycles", low, 2 * HA * BA + HA);
          check("sclk_rises", rises, BA);
        end
        low = 0;
        rises = 0;
        high++;
      end
      sclk_prev = sclk_a;
      csb_prev  = cs_b_a;
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic write_a(input logic [BA-1:0] w);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1;
    wdata_a = w;
    e.rdata = ref_chain;
    e.cfg   = w;
    e.cyc   = cyc + FRAME_A;
    sb_q.push_back(e);
    ref_chain = w;
    @(posedge clk); #1;
    check("c1_busy", busy_a, 1);
    check("c1_cs_b", cs_b_a, 0);
    check("c1_sdi", sdi_a, w[BA-1]);
    @(negedge clk);
    start_a = 1'b0;
    wdata_a = BA'($urandom);
  endtask

  task automatic drain_a();
    int n = 0;
    while (sb_q.size() != 0 && n < 4 * FRAME_A) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d writes still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BA-1:0] w;
    logic [31:0]   tmp;
    logic [BA-1:0] partial;
    int            t0, k, n, got, rises_b;
    logic          sclk_prev_b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_cs_b", cs_b_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_sdi", sdi_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_b_cs_b", cs_b_b, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed pair: second write reads back the first.
    write_a(8'hAC);
    drain_a();
    write_a(8'h53);
    drain_a();

    // Start pulses while busy must be ignored.
    @(negedge clk);
    w = BA'($urandom);
    t0 = cyc;
    start_a = 1'b1;
    wdata_a = w;
    sb_q.push_back('{rdata: ref_chain, cfg: w, cyc: t0 + FRAME_A});
    ref_chain = w;
    @(negedge clk);
    start_a = 1'b0;
    wait_until(t0 + 5);
    start_a = 1'b1;
    wdata_a = BA'($urandom);
    @(negedge clk);
    start_a = 1'b0;
    wait_until(t0 + 20);
    start_a = 1'b1;
    wdata_a = BA'($urandom);
    @(negedge clk);
    start_a = 1'b0;
    drain_a();
    repeat (FRAME_A + 5) @(negedge clk);
    check("busy_after_ignore", busy_a, 0);

    // Random writes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      write_a(BA'($urandom));
      drain_a();
    end

    // Reset in the middle of the shift phase.
    @(negedge clk);
    w = BA'($urandom);
    t0 = cyc;
    start_a = 1'b1;
    wdata_a = w;
    @(negedge clk);
    start_a = 1'b0;
    wait_until(t0 + 30);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_b", cs_b_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_rdata", rdata_a, 0);
    k = 0;
    for (int m = 0; m < BA; m++) if (1 + HA + 2 * HA * m <= 30) k++;
    tmp = (32'(ref_chain) << k) | (32'(w) >> (BA - k));
    partial = tmp[BA-1:0];
    check("abort_cfg_partial", cfg_a, partial);
    ref_chain = partial;
    @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_A) @(negedge clk);
    write_a(BA'($urandom));
    drain_a();

    // Start held high: back-to-back frames.
    @(negedge clk);
    t0 = cyc;
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_until(t0 + i * FRAME_A);
      w = BA'($urandom);
      wdata_a = w;
      sb_q.push_back('{rdata: ref_chain, cfg: w, cyc: t0 + (i + 1) * FRAME_A});
      ref_chain = w;
      if (i == 0) begin
        @(negedge clk);
        gap_chk = 1'b1;
      end
    end
    wait_until(t0 + 3 * FRAME_A);
    start_a = 1'b0;
    drain_a();
    gap_chk = 1'b0;
    repeat (5) @(negedge clk);

    // Four-register chain at the fastest divider.
    @(negedge clk);
    t0 = cyc;
    start_b = 1'b1;
    wdata_b = 32'h0123_4567;
    @(negedge clk);
    start_b = 1'b0;
    wdata_b = '0;
    n = 0;
    got = -1;
    rises_b = 0;
    sclk_prev_b = 1'b0;
    while (got < 0 && n < 4 * FRAME_B) begin
      @(posedge clk); #1;
      n++;
      if (sclk_b && !sclk_prev_b) rises_b++;
      sclk_prev_b = sclk_b;
      if (done_b) got = cyc;
    end
    if (got < 0) begin
      checks++;
      errors++;
      $display("FAIL b_done_timeout: no done within %0d cycles", 4 * FRAME_B);
    end else begin
      check("b_done_cycle", got, t0 + FRAME_B);
    end
    check("b_sclk_rises", rises_b, BB);
    check("b_rdata", rdata_b, CHAIN_B_INIT);
    check("b_reg_tail", cfg_b[31:24], 8'h01);
    check("b_reg_2", cfg_b[23:16], 8'h23);
    check("b_reg_1", cfg_b[15:8], 8'h45);
    check("b_reg_head", cfg_b[7:0], 8'h67);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
